// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle, word-addressed data memory for the MEM stage.
// One load/store is accepted at a time; the pipeline is stalled until the
// access completes, then a one-cycle ack carries the read data or error flag.
module dmem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // WAIT is left when the counter reaches zero, so it starts two below the
    // latency: one cycle is spent in IDLE accepting, one is the final WAIT.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    bad_q;
    logic [31:0]             mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   addr_idx;
    logic                    addr_bad;
    logic                    acc_we;
    logic                    acc_bad;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic                    enter_resp;

    assign addr_idx = addr_i[ADDR_WIDTH+1:2];
    assign addr_bad = (addr_i[1:0] != 2'b00) || (addr_i[31:ADDR_WIDTH+2] != '0);

    // The pipeline only freezes while a request is outstanding and not yet acked.
    assign stall_o = req_i && (state != RESP);

    // Select the request being completed: live inputs when a single-cycle
    // access finishes straight out of IDLE, otherwise the latched copy.
    always_comb begin
        acc_we     = we_q;
        acc_bad    = bad_q;
        acc_idx    = idx_q;
        acc_wdata  = wdata_q;
        enter_resp = 1'b0;
        if (state == IDLE) begin
            acc_we     = we_i;
            acc_bad    = addr_bad;
            acc_idx    = addr_idx;
            acc_wdata  = wdata_i;
            enter_resp = req_i && (LATENCY == 1);
        end else if (state == WAIT) begin
            enter_resp = (cnt == 4'd0);
        end
    end

    // Array storage is not reset; a store commits only on the edge entering
    // RESP, and never while reset is asserted so a dropped store is lost.
    always_ff @(posedge clk_i) begin
        if (enter_resp && acc_we && !acc_bad && !rst_i) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Control FSM: accept, count down the latency, then pulse ack for one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            ack_o <= enter_resp;
            err_o <= enter_resp && acc_bad;
            if (enter_resp) begin
                rdata_o <= (acc_bad || acc_we) ? 32'd0 : mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        idx_q   <= addr_idx;
                        wdata_q <= wdata_i;
                        bad_q   <= addr_bad;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
